vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480 at 60 Hz VGA raster timing from the 100 MHz board clock.
- Produces a pixel-rate enable, column/row counters, active-video flag, hsync/vsync, and line/frame start strobes.
- Sits directly upstream of the pattern-select/colour stage. That stage consumes col_count/row_count and drives the colour pins.
- A configurable delay pipeline on the sync and active outputs keeps them aligned with the downstream registered colour path.

Parameters:
- CLK_DIV, 4: system clocks per pixel; legal ≥1; 100 MHz / 4 = 25 MHz pixel rate.
- H_ACTIVE, 640: visible columns.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible rows.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: asserted level of hsync/vsync (0 = active-low).
- PIPE_DLY, 1: pixel periods of delay applied to hsync, vsync and active; legal 0..4.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- pix_en  out  1  one-clk pulse per pixel period.
- col_count  out  10  current column, 0..H_TOTAL-1 (H_TOTAL = 800).
- row_count  out  10  current row, 0..V_TOTAL-1 (V_TOTAL = 525).
- active  out  1  high while the delayed position is visible.
- hsync  out  1  horizontal sync at SYNC_POL level when asserted.
- vsync  out  1  vertical sync at SYNC_POL level when asserted.
- line_start  out  1  one-clk strobe at the start of each line.
- frame_start  out  1  one-clk strobe at the start of each frame.

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst. All state updates on the rising edge of clk.
- Reset values:
  - divider = 0, pix_en = 0, col_count = 0, row_count = 0.
  - active = 0, line_start = 0, frame_start = 0.
  - hsync = vsync = ~SYNC_POL.
  - All PIPE_DLY stages cleared to the deasserted value.
- Divider:
  - Counts 0..CLK_DIV-1, wraps to 0.
  - pix_en = 1 exactly while divider == CLK_DIV-1.
  - With CLK_DIV=1, pix_en = 1 on every cycle out of reset.
  - First pix_en is the CLK_DIV-th clock after rst falls.
- Counters advance only on edges where pix_en = 1:
  - col_count increments.
  - At H_TOTAL-1 (799), col_count wraps to 0 and row_count increments.
  - At col 799 with row 524, both wrap to 0.
- Undelayed decodes, from the current counters:
  - h_sync_raw asserted for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - v_sync_raw asserted for row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491].
  - act_raw = (col < 640) && (row < 480).
- Delay pipeline:
  - hsync, vsync and active equal the raw decodes delayed by PIPE_DLY pixel periods.
  - Stages shift only on pix_en.
  - PIPE_DLY=0: outputs track the counters in the same cycle, glitch-free (registered from the next-count decode).
- Strobes:
  - line_start = pix_en && col_count == 0.
  - frame_start = pix_en && col_count == 0 && row_count == 0.
  - Both are single-clk strobes, undelayed, and coincide with pix_en.
- Totals per frame:
  - Frame = 420000 pixel periods = 1,680,000 clks at CLK_DIV=4.
  - hsync asserted 96 pixels per line.
  - vsync asserted 1600 pixel periods per frame.
- Boundary conditions:
  - Reset mid-frame: the next cycle shows all reset values, with no partial sync pulse.
  - After release, the first pix_en produces frame_start because the counters are at (0,0).
  - rst dominates pix_en on the same edge.
  - Counter arithmetic is unsigned 10-bit; H_TOTAL and V_TOTAL must be ≤1024 (elaboration-time check).

Test Plan:
- Reset and divider: rst high 5 clks, then low → pix_en first high on the 4th clk after release, then every 4 clks. During reset, hsync = vsync = 1, active = 0, counters 0. frame_start pulses with the first pix_en.
- Line timing, PIPE_DLY=0: hsync goes low when col_count = 656 and high when col_count = 752 (96 pix_en). col 799 → 0 with row incrementing; line_start once per 800 pix_en.
- Frame timing: vsync is low for exactly 1600 pix_en while row_count ∈ {490, 491}. row 524 → 0; frame_start exactly once per 420000 pix_en (1,680,000 clks).
- Active window: active is high for exactly 307200 pix_en per frame. It falls at col 640 and rises at col 0 for rows 0..479, and stays low for rows 480..524.
- Delay, PIPE_DLY=2: hsync falls while col_count = 658 and active falls while col_count = 642. line_start timing is unchanged.
- Mid-frame reset: rst pulsed 1 clk at row 300, col 400 → next clk counters = 0, hsync = vsync = 1, active = 0, pipeline cleared. frame_start occurs 4 clks after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate enable, column/row counters,
// delayed active/hsync/vsync decodes and line/frame start strobes.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] col_count,
  output logic [9:0] row_count,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CMP_W   = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Decode windows held one bit wider so an end bound of 1024 does not wrap.
  localparam logic [CMP_W-1:0] H_ACT_END  = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] V_ACT_END  = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] HS_START   = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] HS_STOP    = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] VS_START   = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] VS_STOP    = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON = 1'(SYNC_POL);

  localparam int unsigned TAP_HS  = 0;
  localparam int unsigned TAP_VS  = 1;
  localparam int unsigned TAP_ACT = 2;
  localparam int unsigned TAP_W   = 3;

  // Parameter legality, caught at elaboration.
  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (PIPE_DLY > 4) begin : g_chk_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..4");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_chk_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;
  logic             pix_en_nxt;
  logic [CNT_W-1:0] col_nxt;
  logic [CNT_W-1:0] row_nxt;
  logic [TAP_W-1:0] raw_nxt;
  logic [TAP_W-1:0] tap [PIPE_DLY+1];

  // Next divider/counter state and the raw decode of the next position.
  always_comb begin
    div_nxt    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_en_nxt = (div_nxt == DIV_LAST);
    col_nxt    = col_count;
    row_nxt    = row_count;
    raw_nxt    = '0;

    if (pix_en) begin
      if (col_count == H_LAST) begin
        col_nxt = '0;
        row_nxt = (row_count == V_LAST) ? '0 : row_count + CNT_W'(1);
      end else begin
        col_nxt = col_count + CNT_W'(1);
      end
    end

    raw_nxt[TAP_HS]  = (CMP_W'(col_nxt) >= HS_START) && (CMP_W'(col_nxt) < HS_STOP);
    raw_nxt[TAP_VS]  = (CMP_W'(row_nxt) >= VS_START) && (CMP_W'(row_nxt) < VS_STOP);
    raw_nxt[TAP_ACT] = (CMP_W'(col_nxt) < H_ACT_END) && (CMP_W'(row_nxt) < V_ACT_END);
  end

  // tap[0] always mirrors the current position; tap[k] lags it by k pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      pix_en      <= 1'b0;
      col_count   <= '0;
      row_count   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      for (int unsigned k = 0; k <= PIPE_DLY; k++) begin
        tap[k] <= '0;
      end
    end else begin
      div_q       <= div_nxt;
      pix_en      <= pix_en_nxt;
      col_count   <= col_nxt;
      row_count   <= row_nxt;
      line_start  <= pix_en_nxt && (col_nxt == '0);
      frame_start <= pix_en_nxt && (col_nxt == '0) && (row_nxt == '0);
      tap[0]      <= raw_nxt;
      if (pix_en) begin
        for (int unsigned k = 1; k <= PIPE_DLY; k++) begin
          tap[k] <= tap[k-1];
        end
      end
    end
  end

  // Polarity is a constant inversion of registered flags, so pins stay glitch-free.
  assign active = tap[PIPE_DLY][TAP_ACT];
  assign hsync  = tap[PIPE_DLY][TAP_HS] ? SYNC_ON : ~SYNC_ON;
  assign vsync  = tap[PIPE_DLY][TAP_VS] ? SYNC_ON : ~SYNC_ON;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size line timing at two pipeline
// depths plus a shrunken raster for whole-frame totals and mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_c;

  logic       pix_en_a, active_a, hsync_a, vsync_a, line_start_a, frame_start_a;
  logic [9:0] col_a, row_a;
  logic       pix_en_b, active_b, hsync_b, vsync_b, line_start_b, frame_start_b;
  logic [9:0] col_b, row_b;
  logic       pix_en_c, active_c, hsync_c, vsync_c, line_start_c, frame_start_c;
  logic [9:0] col_c, row_c;

  // Full 640x480 geometry, no output delay.
  vga_timing_gen #(.PIPE_DLY(0)) dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en_a), .col_count(col_a), .row_count(row_a),
    .active(active_a), .hsync(hsync_a), .vsync(vsync_a),
    .line_start(line_start_a), .frame_start(frame_start_a)
  );

  // Full geometry, two-pixel output delay.
  vga_timing_gen #(.PIPE_DLY(2)) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en_b), .col_count(col_b), .row_count(row_b),
    .active(active_b), .hsync(hsync_b), .vsync(vsync_b),
    .line_start(line_start_b), .frame_start(frame_start_b)
  );

  // Tiny raster: H_TOTAL=15, V_TOTAL=10, active-high sync, one-pixel delay.
  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1), .PIPE_DLY(1)
  ) dut_c (
    .clk(clk), .rst(rst_c), .pix_en(pix_en_c), .col_count(col_c), .row_count(row_c),
    .active(active_c), .hsync(hsync_c), .vsync(vsync_c),
    .line_start(line_start_c), .frame_start(frame_start_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic goto_c(input logic [9:0] col, input logic [9:0] row);
    int  n   = 0;
    logic hit = 1'b0;
    while (n < 1000 && !hit) begin
      if (col_c == col && row_c == row) hit = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk("goto_c_reached", 32'(hit), 1);
  endtask

  int n_pix, n_hs, n_vs, n_ls, n_fs, n_act;
  logic [9:0] hs_fall_a, hs_rise_a, act_fall_a, hs_fall_b, act_fall_b;
  logic prev_hs_a, prev_act_a, prev_hs_b, prev_act_b;

  initial begin
    rst   = 1'b1;
    rst_c = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_pix_en",      32'(pix_en_a), 0);
    chk("rst_col",         32'(col_a), 0);
    chk("rst_row",         32'(row_a), 0);
    chk("rst_hsync",       32'(hsync_a), 1);
    chk("rst_vsync",       32'(vsync_a), 1);
    chk("rst_active",      32'(active_a), 0);
    chk("rst_frame_start", 32'(frame_start_a), 0);
    chk("rst_c_hsync",     32'(hsync_c), 0);
    chk("rst_c_vsync",     32'(vsync_c), 0);

    // Divider start-up: pix_en once the divider reaches 3
    rst = 1'b0;
    step();
    step();
    chk("rel_pix_en_early", 32'(pix_en_a), 0);
    step();
    chk("rel_pix_en_first",  32'(pix_en_a), 1);
    chk("rel_frame_start",   32'(frame_start_a), 1);
    chk("rel_line_start",    32'(line_start_a), 1);
    chk("rel_col",           32'(col_a), 0);
    chk("rel_active_dly0",   32'(active_a), 1);
    chk("rel_active_dly2",   32'(active_b), 0);
    chk("rel_pix_en_b",      32'(pix_en_b), 1);
    step();
    chk("pix_en_gap", 32'(pix_en_a), 0);
    step();
    step();
    step();
    chk("pix_en_period", 32'(pix_en_a), 1);
    chk("col_after_one", 32'(col_a), 1);

    // One full line (800 pixels) on the full-size instances
    repeat (3196) step();
    chk("line0_boundary_pix_en", 32'(pix_en_a), 1);
    chk("line1_col0",            32'(col_a), 0);
    chk("line1_row1",            32'(row_a), 1);
    n_pix = 0; n_hs = 0; n_ls = 0; n_act = 0;
    hs_fall_a = '1; hs_rise_a = '1; act_fall_a = '1; hs_fall_b = '1; act_fall_b = '1;
    prev_hs_a = hsync_a; prev_act_a = active_a;
    prev_hs_b = hsync_b; prev_act_b = active_b;
    for (int i = 0; i < 3200; i++) begin
      if (pix_en_a) begin
        n_pix++;
        if (!hsync_a)     n_hs++;
        if (line_start_a) n_ls++;
        if (active_a)     n_act++;
      end
      if (prev_hs_a && !hsync_a)   hs_fall_a  = col_a;
      if (!prev_hs_a && hsync_a)   hs_rise_a  = col_a;
      if (prev_act_a && !active_a) act_fall_a = col_a;
      if (prev_hs_b && !hsync_b)   hs_fall_b  = col_b;
      if (prev_act_b && !active_b) act_fall_b = col_b;
      prev_hs_a = hsync_a; prev_act_a = active_a;
      prev_hs_b = hsync_b; prev_act_b = active_b;
      step();
    end
    chk("line_pix_count",    32'(n_pix), 800);
    chk("line_hsync_count",  32'(n_hs), 96);
    chk("line_start_count",  32'(n_ls), 1);
    chk("line_active_count", 32'(n_act), 640);
    chk("hsync_fall_col",    32'(hs_fall_a), 656);
    chk("hsync_rise_col",    32'(hs_rise_a), 752);
    chk("active_fall_col",   32'(act_fall_a), 640);
    chk("dly2_hsync_fall",   32'(hs_fall_b), 658);
    chk("dly2_active_fall",  32'(act_fall_b), 642);
    chk("line2_col0",        32'(col_a), 0);
    chk("line2_row2",        32'(row_a), 2);
    chk("line2_line_start",  32'(line_start_a), 1);
    chk("line2_no_frame",    32'(frame_start_a), 0);
    chk("line2_dly2_ls",     32'(line_start_b), 1);

    // Tiny raster: whole frame of 150 pixels at CLK_DIV=2
    chk("c_rst_active", 32'(active_c), 0);
    rst_c = 1'b0;
    step();
    chk("c_first_pix_en",  32'(pix_en_c), 1);
    chk("c_first_frame",   32'(frame_start_c), 1);
    chk("c_first_active",  32'(active_c), 0);
    n_pix = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0; n_act = 0;
    for (int i = 0; i < 300; i++) begin
      if (pix_en_c) begin
        n_pix++;
        if (hsync_c)       n_hs++;
        if (vsync_c)       n_vs++;
        if (line_start_c)  n_ls++;
        if (frame_start_c) n_fs++;
        if (active_c)      n_act++;
      end
      step();
    end
    chk("c_frame_pix",    32'(n_pix), 150);
    chk("c_frame_hsync",  32'(n_hs), 30);
    chk("c_frame_vsync",  32'(n_vs), 30);
    chk("c_frame_lines",  32'(n_ls), 10);
    chk("c_frame_starts", 32'(n_fs), 1);
    chk("c_frame_active", 32'(n_act), 48);
    chk("c_wrap_frame",   32'(frame_start_c), 1);
    chk("c_wrap_row",     32'(row_c), 0);
    chk("c_wrap_col",     32'(col_c), 0);

    // Mid-frame reset while both syncs are asserted
    goto_c(10'd11, 10'd7);
    chk("c_pre_hsync", 32'(hsync_c), 1);
    chk("c_pre_vsync", 32'(vsync_c), 1);
    rst_c = 1'b1;
    step();
    chk("c_mid_col",    32'(col_c), 0);
    chk("c_mid_row",    32'(row_c), 0);
    chk("c_mid_hsync",  32'(hsync_c), 0);
    chk("c_mid_vsync",  32'(vsync_c), 0);
    chk("c_mid_active", 32'(active_c), 0);
    chk("c_mid_pix_en", 32'(pix_en_c), 0);
    chk("c_mid_ls",     32'(line_start_c), 0);
    rst_c = 1'b0;
    step();
    chk("c_after_frame",  32'(frame_start_c), 1);
    chk("c_after_hsync",  32'(hsync_c), 0);
    chk("c_after_vsync",  32'(vsync_c), 0);
    chk("c_after_active", 32'(active_c), 0);
    step();
    step();
    chk("c_after_col1",    32'(col_c), 1);
    chk("c_after_active1", 32'(active_c), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
